// File: rtl/alu_pkg.sv
// Shared constants for the multicycle ALU: operation classes, opcodes,
// controller state encoding and the op descriptor.
package alu_pkg;

  localparam logic [1:0] CLS_SHIFT  = 2'b00;
  localparam logic [1:0] CLS_MULDIV = 2'b01;
  localparam logic [1:0] CLS_ARITH  = 2'b10;
  localparam logic [1:0] CLS_LOGIC  = 2'b11;

  localparam logic [1:0] OP_SRL  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b01;
  localparam logic [1:0] OP_SLTU = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0] cls;
    logic [1:0] op;
  } op_t;

  // True for the ops that go through the iterative datapath
  function automatic logic is_iter(op_t o);
    return (o.cls == CLS_MULDIV) && ((o.op == OP_MULU) || (o.op == OP_DIVU));
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit
// per cycle; done pulses for one cycle once all N iterations have run.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned NW = N + 1;

  logic          busy;
  logic          mode_q;
  logic [CW-1:0] cnt;
  logic [N-1:0]  d;
  logic [N-1:0]  hi_nx;
  logic [N-1:0]  lo_nx;
  logic [NW-1:0] mul_sum;
  logic [NW-1:0] div_sh;

  assign done = busy && (cnt == '0);

  // One iteration: hi/lo hold {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    hi_nx   = hi;
    lo_nx   = lo;
    mul_sum = '0;
    div_sh  = '0;
    if (mode_q == MD_MUL) begin
      mul_sum        = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
      {hi_nx, lo_nx} = {mul_sum, lo[N-1:1]};
    end else begin
      div_sh = {hi, lo[N-1]};
      if (div_sh >= {1'b0, d}) begin
        hi_nx = N'(div_sh - {1'b0, d});
        lo_nx = {lo[N-2:0], 1'b1};
      end else begin
        hi_nx = div_sh[N-1:0];
        lo_nx = {lo[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      mode_q <= MD_MUL;
      cnt    <= '0;
      d      <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      cnt    <= CW'(N);
      d      <= (mode == MD_DIV) ? b : a;
      hi     <= '0;
      lo     <= (mode == MD_DIV) ? a : b;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        hi  <= hi_nx;
        lo  <= lo_nx;
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU with valid/ready handshake: single-cycle shift/arith/logic
// classes plus iterative unsigned MULU/DIVU, all results registered.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   opcode,
  input  logic [1:0]   fnClass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic         zerof,
  output logic         ovf,
  output logic         c_out
);

  localparam int unsigned SHW = $clog2(N);
  localparam int unsigned SW1 = SHW + 1;
  localparam int unsigned NW  = N + 1;

  state_t         state;
  state_t         state_nx;
  op_t            op_in;
  logic           iter_op;
  logic           accept;
  logic           md_start;
  logic           md_done;
  logic           load_sc;
  logic           load_md;
  logic           md_div_q;
  logic           md_bz_q;
  logic [N-1:0]   md_lo;
  logic [N-1:0]   md_hi;

  logic [SHW-1:0] shamt;
  logic [SHW-1:0] srl_idx;
  logic [SHW-1:0] sll_idx;
  logic [SHW:0]   rol_rsh;
  logic           is_sub;
  logic [N-1:0]   b_eff;
  logic [NW-1:0]  sum;
  logic [N-1:0]   sc_out;
  logic           sc_ovf;
  logic           sc_c;

  assign op_in   = '{cls: fnClass, op: opcode};
  assign iter_op = is_iter(op_in);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: a drain edge may also accept the following op
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)                              state_nx = iter_op ? ST_EXEC : ST_DONE;
        else if ((state == ST_DONE) && out_ready) state_nx = ST_IDLE;
      end
      ST_EXEC: if (md_done) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake and load strobes decoded from state
  always_comb begin
    out_valid = (state == ST_DONE);
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    accept    = in_valid && in_ready;
    md_start  = accept && iter_op;
    load_sc   = accept && !iter_op;
    load_md   = (state == ST_EXEC) && md_done;
  end

  assign shamt   = b[SHW-1:0];
  assign srl_idx = shamt - SHW'(1);
  assign sll_idx = SHW'(0) - shamt;
  assign rol_rsh = SW1'(N) - {1'b0, shamt};
  assign is_sub  = (opcode == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + NW'(is_sub);

  // Single-cycle classes; reserved muldiv opcodes fall through as zero
  always_comb begin
    sc_out = '0;
    sc_ovf = 1'b0;
    sc_c   = 1'b0;
    case (fnClass)
      CLS_SHIFT: begin
        case (opcode)
          OP_SRL: begin
            sc_out = a >> shamt;
            sc_c   = (shamt != '0) && a[srl_idx];
          end
          OP_SLL: begin
            sc_out = a << shamt;
            sc_c   = (shamt != '0) && a[sll_idx];
          end
          OP_SRA: begin
            sc_out = $unsigned($signed(a) >>> shamt);
            sc_c   = (shamt != '0) && a[srl_idx];
          end
          default: sc_out = (a << shamt) | (a >> rol_rsh);
        endcase
      end
      CLS_ARITH: begin
        case (opcode)
          OP_SLT:  sc_out = N'($signed(a) < $signed(b));
          OP_SLTU: sc_out = N'(a < b);
          default: begin
            sc_out = sum[N-1:0];
            sc_c   = sum[N];
            sc_ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
          end
        endcase
      end
      CLS_LOGIC: begin
        case (opcode)
          OP_AND:  sc_out = a & b;
          OP_OR:   sc_out = a | b;
          OP_XOR:  sc_out = a ^ b;
          default: sc_out = ~(a | b);
        endcase
      end
      default: sc_out = '0;
    endcase
  end

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .mode  ((opcode == OP_DIVU) ? MD_DIV : MD_MUL),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  // Result registers hold until the next load, so backpressure keeps them stable
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      out_hi   <= '0;
      zerof    <= 1'b0;
      ovf      <= 1'b0;
      c_out    <= 1'b0;
      md_div_q <= 1'b0;
      md_bz_q  <= 1'b0;
    end else begin
      if (md_start) begin
        md_div_q <= (opcode == OP_DIVU);
        md_bz_q  <= (b == '0);
      end
      if (load_sc) begin
        out    <= sc_out;
        out_hi <= '0;
        zerof  <= (sc_out == '0);
        ovf    <= sc_ovf;
        c_out  <= sc_c;
      end else if (load_md) begin
        out    <= md_lo;
        out_hi <= md_hi;
        zerof  <= (md_lo == '0);
        ovf    <= md_div_q ? md_bz_q : (md_hi != '0);
        c_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: reference model feeds a scoreboard queue,
// results are popped and compared when the DUT presents them.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   opcode;
  logic [1:0]   fnClass;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [N-1:0] out_hi;
  logic         zerof;
  logic         ovf;
  logic         c_out;

  alu_mc #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .fnClass   (fnClass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .zerof     (zerof),
    .ovf       (ovf),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic [31:0] h;
    logic        z;
    logic        v;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input logic [1:0] cls, input logic [1:0] op,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [4:0]  sh;
    logic [63:0] p;
    longint      sx;
    longint      sy;
    longint      sr;
    e.o = '0; e.h = '0; e.z = 1'b0; e.v = 1'b0; e.c = 1'b0; e.lat = 0;
    sh = y[4:0];
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (cls)
      2'd0: case (op)
        2'd0: begin e.o = x >> sh; e.c = (sh != 5'd0) ? x[sh - 5'd1] : 1'b0; end
        2'd1: begin e.o = x << sh; e.c = (sh != 5'd0) ? x[5'd0 - sh] : 1'b0; end
        2'd2: begin e.o = $unsigned($signed(x) >>> sh); e.c = (sh != 5'd0) ? x[sh - 5'd1] : 1'b0; end
        default: e.o = (x << sh) | (x >> (6'd32 - {1'b0, sh}));
      endcase
      2'd1: case (op)
        2'd0: begin
          p = {32'd0, x} * {32'd0, y};
          e.o = p[31:0]; e.h = p[63:32]; e.v = (e.h != 32'd0); e.lat = 33;
        end
        2'd1: begin
          if (y == 32'd0) begin e.o = 32'hFFFF_FFFF; e.h = x; e.v = 1'b1; end
          else begin e.o = x / y; e.h = x % y; end
          e.lat = 33;
        end
        default: e.o = '0;
      endcase
      2'd2: case (op)
        2'd0: begin
          p = {32'd0, x} + {32'd0, y};
          e.o = p[31:0]; e.c = p[32];
          sr = sx + sy;
          e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        2'd1: e.o = {31'd0, sx < sy};
        2'd2: e.o = {31'd0, x < y};
        default: begin
          e.o = x - y; e.c = (x >= y);
          sr = sx - sy;
          e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
      endcase
      default: case (op)
        2'd0: e.o = x & y;
        2'd1: e.o = x | y;
        2'd2: e.o = x ^ y;
        default: e.o = ~(x | y);
      endcase
    endcase
    e.z = (e.o == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cls, input logic [1:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    sb.push_back(model(cls, op, x, y));
    fnClass  = cls;
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    fnClass  = 2'($urandom_range(3));
    opcode   = 2'($urandom_range(3));
  endtask

  task automatic send(input string tag, input logic [1:0] cls, input logic [1:0] op,
                      input logic [31:0] x, input logic [31:0] y);
    int n;
    drive(cls, op, x, y);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 scramble();
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   edges;
    logic ready_seen;
    check({tag, ".sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e          = sb[0];
    edges      = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && edges < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      edges++;
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".latency"}, 64'(edges), 64'(e.lat));
    if (e.lat != 0) check({tag, ".busy_ready"}, 64'(ready_seen), 64'd0);
    check({tag, ".out"},    64'(out),    64'(e.o));
    check({tag, ".out_hi"}, 64'(out_hi), 64'(e.h));
    check({tag, ".zerof"},  64'(zerof),  64'(e.z));
    check({tag, ".ovf"},    64'(ovf),    64'(e.v));
    check({tag, ".c_out"},  64'(c_out),  64'(e.c));
  endtask

  task automatic drain();
    @(posedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    #1;
  endtask

  task automatic run(input string tag, input logic [1:0] cls, input logic [1:0] op,
                     input logic [31:0] x, input logic [31:0] y);
    send(tag, cls, op, x, y);
    collect(tag);
    drain();
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; opcode = '0; fnClass = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.out",       64'(out),       64'd0);

    run("add_small",  CLS_ARITH, OP_ADD,  32'h3,         32'h2);
    run("add_ovf",    CLS_ARITH, OP_ADD,  32'h7FFF_FFFF, 32'h1);
    run("add_carry",  CLS_ARITH, OP_ADD,  32'hFFFF_FFFF, 32'h1);
    run("sub_pos",    CLS_ARITH, OP_SUB,  32'h5,         32'h2);
    run("sub_zero",   CLS_ARITH, OP_SUB,  32'h2,         32'h2);
    run("sub_borrow", CLS_ARITH, OP_SUB,  32'h2,         32'h5);
    run("sub_ovf",    CLS_ARITH, OP_SUB,  32'h8000_0000, 32'h1);
    run("slt",        CLS_ARITH, OP_SLT,  32'hFFFF_FFFF, 32'h1);
    run("sltu",       CLS_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    run("and",        CLS_LOGIC, OP_AND,  32'h5,         32'h3);
    run("or",         CLS_LOGIC, OP_OR,   32'hF0F0_0000, 32'h0000_0F0F);
    run("xor",        CLS_LOGIC, OP_XOR,  32'hFFFF_0000, 32'hFF00_FF00);
    run("nor",        CLS_LOGIC, OP_NOR,  32'h0000_FFFF, 32'h00FF_0000);
    run("sll",        CLS_SHIFT, OP_SLL,  32'h5,         32'd3);
    run("sll_out",    CLS_SHIFT, OP_SLL,  32'h8000_0000, 32'd1);
    run("srl",        CLS_SHIFT, OP_SRL,  32'h8000_0001, 32'd1);
    run("srl_zero",   CLS_SHIFT, OP_SRL,  32'h8000_0001, 32'd0);
    run("sra",        CLS_SHIFT, OP_SRA,  32'h8000_0080, 32'd8);
    run("rol",        CLS_SHIFT, OP_ROL,  32'h8000_0001, 32'd4);
    run("rol_big_b",  CLS_SHIFT, OP_ROL,  32'h1234_5678, 32'hFFFF_FF28);
    run("mulu_wide",  CLS_MULDIV, OP_MULU, 32'hFFFF_FFFF, 32'h2);
    run("mulu_small", CLS_MULDIV, OP_MULU, 32'h0001_2345, 32'h0000_6789);
    run("divu",       CLS_MULDIV, OP_DIVU, 32'd100,       32'd7);
    run("divu_zero",  CLS_MULDIV, OP_DIVU, 32'h7,         32'h0);
    run("md_resv",    CLS_MULDIV, 2'b10,   32'h1234,      32'h5678);

    // Backpressure: hold an ADD result, then drain it while accepting an OR
    out_ready = 1'b0;
    send("bp_add", CLS_ARITH, OP_ADD, 32'h1111_0000, 32'h0000_2222);
    collect("bp_add");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d.out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d.in_ready", i),  64'(in_ready),  64'd0);
      check($sformatf("bp_hold%0d.out", i),       64'(out),       64'(sb[0].o));
    end
    out_ready = 1'b1;
    drive(CLS_LOGIC, OP_OR, 32'h0000_00A0, 32'h0000_000B);
    #1 check("bp_or.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    void'(sb.pop_front());
    #1 scramble();
    collect("bp_or");
    drain();

    // Reset in the tenth EXEC cycle aborts the multiply
    send("abort_mulu", CLS_MULDIV, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1 check("abort.busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.in_ready",  64'(in_ready),  64'd1);
    check("abort.out",       64'(out),       64'd0);
    check("abort.out_hi",    64'(out_hi),    64'd0);
    check("abort.flags",     64'({zerof, ovf, c_out}), 64'd0);
    run("post_abort_add", CLS_ARITH, OP_ADD, 32'h10, 32'h20);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort.no_stale", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multicycle ALU, the successor to the combinational 32-bit ALU.
- Keeps the fnClass/opcode operation scheme and the zerof/ovf/c_out flags.
- Adds a valid/ready handshake, registered results, and an iterative unsigned multiply/divide class.
- Sits between the operand-fetch stage and writeback. Single-cycle classes complete in 1 cycle; MULU/DIVU take N+1 cycles.

Parameters:
- N, 32, operand/result width (≥4, power of 2).
- SHW, $clog2(N), shift-amount width, derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an op.
- a  in  N  operand A.
- b  in  N  operand B, or shift amount in b[SHW-1:0].
- opcode  in  2  operation within class.
- fnClass  in  2  00 shift, 01 muldiv, 10 arithmetic, 11 logic.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  N  result low word / quotient.
- out_hi  out  N  MULU high word / DIVU remainder; 0 for other ops.
- zerof  out  1  out == 0 (low word only).
- ovf  out  1  overflow / exception flag.
- c_out  out  1  carry / shifted-out bit.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high (clk, rst). On rst, regardless of state, the next edge gives: state IDLE; out_valid, out, out_hi, zerof, ovf, c_out = 0; any in-flight MULU/DIVU is aborted with no result produced.
- Handshake:
  - Op accepted on an edge where in_valid && in_ready.
  - Result transferred on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, out/out_hi/flags are held stable.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new op may be accepted on the same edge the old result is drained.
- FSM:
  - IDLE → DONE on accepting a shift, arith, logic or reserved op. out_valid is high in the cycle after the accept edge (latency 1).
  - IDLE/DONE → EXEC on accepting MULU/DIVU. A counter is loaded with N; one iteration runs per cycle.
  - EXEC → DONE after N iterations; out_valid rises N+1 edges after accept. in_ready is 0 throughout EXEC.
  - DONE → IDLE on a drain edge with no simultaneous accept. DONE → DONE/EXEC on a drain edge with a simultaneous accept.
- Shift (fnClass 00), shamt = b[SHW-1:0]:
  - 00 SRL, 01 SLL, 10 SRA, 11 ROL.
  - c_out = last bit shifted out; 0 when shamt==0 and for ROL.
  - ovf = 0.
- Muldiv (fnClass 01), unsigned:
  - 00 MULU: shift-add, {out_hi,out} = a*b; ovf = (out_hi != 0).
  - 01 DIVU: restoring division; out = quotient, out_hi = remainder. For b==0: out = all-ones, out_hi = a, ovf = 1, still N cycles.
  - 10/11 reserved: single-cycle, out = 0, out_hi = 0, ovf = 0.
  - c_out = 0 for all muldiv ops.
- Arithmetic (fnClass 10):
  - 00 ADD: c_out = carry out of bit N-1.
  - 01 SLT: signed, out = {0…,lt}.
  - 10 SLTU: unsigned, out = {0…,lt}.
  - 11 SUB: computed as a + ~b + 1; c_out = carry = no borrow (a ≥ b unsigned).
  - ovf = signed overflow for ADD/SUB; 0 for SLT/SLTU, and c_out = 0 for SLT/SLTU.
- Logic (fnClass 11): 00 AND, 01 OR, 10 XOR, 11 NOR; ovf = c_out = 0.
- All arithmetic is modulo 2^N except the 2N-bit MULU product.
- Operands are captured at accept. Input changes during EXEC have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - class localparams CLS_SHIFT, CLS_MULDIV, CLS_ARITH, CLS_LOGIC;
  - per-class opcode localparams, e.g. OP_ADD=00, OP_SUB=11, OP_SLL=01, OP_AND=00, OP_MULU=00, OP_DIVU=01;
  - FSM state encoding ST_IDLE/ST_EXEC/ST_DONE.
- Sub-module alu_muldiv_iter implements the iterative MULU/DIVU datapath:
  - inputs start, mode, a, b; outputs done, lo, hi;
  - its own bit counter;
  - clk, rst shared with the parent.
- Single-cycle classes stay in alu_mc as a combinational mux feeding the output registers.

Test Plan:
- ADD a=0x3, b=0x2, out_ready=1 → one cycle later out_valid=1, out=0x5, zerof=0, ovf=0, c_out=0; ADD 0x7FFFFFFF+0x1 → out=0x80000000, ovf=1.
- SUB a=0x5, b=0x2 → out=0x3, c_out=1; SUB a=0x2, b=0x2 → out=0, zerof=1, c_out=1; AND 0x5&0x3 → out=0x1; SLL a=0x5, shamt=3 → out=0x28, c_out=0.
- MULU a=0xFFFFFFFF, b=0x2 → in_ready=0 for 32 cycles, out_valid at edge 33, out=0xFFFFFFFE, out_hi=0x1, ovf=1; DIVU 100/7 → out=14, out_hi=2, ovf=0.
- DIVU a=0x7, b=0 → out=0xFFFFFFFF, out_hi=0x7, ovf=1, latency N+1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD → outputs stable, in_ready=0. Raise out_ready with in_valid=1 (OR op) → result drained and new op accepted on the same edge; OR result valid next cycle.
- Assert rst at the 10th EXEC cycle of a MULU → next edge out_valid=0, all outputs 0, in_ready=1. A subsequent ADD completes normally with no stale MULU result.
